// File: rtl/mcu_run_ctrl_pkg.sv
// Shared types for the MCU run/debug sequencer.
// State encoding, host command opcodes and counter width default.
package mcu_run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_HALTED = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_DRAIN  = 3'd4
    } state_e;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_RUN   = 3'd1;
    localparam logic [2:0] OP_HALT  = 3'd2;
    localparam logic [2:0] OP_STEP  = 3'd3;
    localparam logic [2:0] OP_RESET = 3'd4;
    localparam logic [2:0] OP_SETBP = 3'd5;
    localparam logic [2:0] OP_CLRBP = 3'd6;

    localparam int CNT_WIDTH_DEF = 16;

    // States in which the core clock is enabled
    function automatic logic core_active(state_e s);
        return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
    endfunction

    // States in which host commands are taken
    function automatic logic cmd_open(state_e s);
        return (s == ST_HALTED) || (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/mcu_run_ctrl_bkpt.sv
// PC breakpoint register pair and comparator.
// Only instantiated when MCU_RUN_CTRL_BKPT_EN is defined.
module mcu_bkpt_unit
    import mcu_run_ctrl_pkg::*;
#(
    parameter int PC_WIDTH = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                set_i,
    input  logic                clr_i,
    input  logic [PC_WIDTH-1:0] arg_i,
    input  logic [PC_WIDTH-1:0] pc_i,
    input  logic                fetch_i,
    output logic                match_o
);

    logic [PC_WIDTH-1:0] bkpt_pc_q, bkpt_pc_d;
    logic                bkpt_en_q, bkpt_en_d;

    // Load or disable the breakpoint on host command
    always_comb begin
        bkpt_pc_d = bkpt_pc_q;
        bkpt_en_d = bkpt_en_q;
        if (set_i) begin
            bkpt_pc_d = arg_i;
            bkpt_en_d = 1'b1;
        end else if (clr_i) begin
            bkpt_en_d = 1'b0;
        end
    end

    // Breakpoint registers, cleared by system reset only
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            bkpt_pc_q <= '0;
            bkpt_en_q <= 1'b0;
        end else begin
            bkpt_pc_q <= bkpt_pc_d;
            bkpt_en_q <= bkpt_en_d;
        end
    end

    assign match_o = bkpt_en_q && fetch_i && (pc_i == bkpt_pc_q);

endmodule

// File: rtl/mcu_run_ctrl.sv
// Run/debug sequencer owning the MCU core reset and clock enable.
// Define MCU_RUN_CTRL_BKPT_EN to build in the PC breakpoint.
module mcu_run_ctrl
    import mcu_run_ctrl_pkg::*;
#(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  BOOT_CYCLES = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [PC_WIDTH-1:0]  cmd_arg,
    input  logic [PC_WIDTH-1:0]  currentPC,
    input  logic                 fetch_pulse,
    output logic                 core_rst_n,
    output logic                 core_en,
    output logic [PC_WIDTH-1:0]  boot_pc,
    output logic [2:0]           state_o,
    output logic                 bkpt_hit,
    output logic [CNT_WIDTH-1:0] insn_count
);

    localparam int BW = $clog2(BOOT_CYCLES + 1);
    localparam logic [BW-1:0] BOOT_LOAD = BW'(BOOT_CYCLES);

    state_e               state_q, state_d;
    logic [BW-1:0]        boot_cnt_q, boot_cnt_d;
    logic [PC_WIDTH-1:0]  step_left_q, step_left_d;
    logic [PC_WIDTH-1:0]  boot_pc_q, boot_pc_d;
    logic [CNT_WIDTH-1:0] insn_count_q, insn_count_d;
    logic                 bkpt_hit_q, bkpt_hit_d;
    logic                 core_rst_n_q, core_rst_n_d;
    logic                 core_en_q, core_en_d;
    logic                 cmd_ready_q, cmd_ready_d;

    logic cmd_acc;
    logic op_run, op_halt, op_step, op_reset;
    logic bkpt_match, bkpt_fire;

    assign cmd_acc  = cmd_valid && cmd_ready_q;
    assign op_run   = cmd_acc && (cmd_op == OP_RUN);
    assign op_halt  = cmd_acc && (cmd_op == OP_HALT);
    assign op_step  = cmd_acc && (cmd_op == OP_STEP);
    assign op_reset = cmd_acc && (cmd_op == OP_RESET);

`ifdef MCU_RUN_CTRL_BKPT_EN
    mcu_bkpt_unit #(
        .PC_WIDTH (PC_WIDTH)
    ) u_bkpt (
        .Clk     (Clk),
        .Reset   (Reset),
        .set_i   (cmd_acc && (cmd_op == OP_SETBP)),
        .clr_i   (cmd_acc && (cmd_op == OP_CLRBP)),
        .arg_i   (cmd_arg),
        .pc_i    (currentPC),
        .fetch_i (fetch_pulse),
        .match_o (bkpt_match)
    );
`else
    logic unused_pc;
    assign unused_pc  = ^currentPC;
    assign bkpt_match = 1'b0;
`endif

    assign bkpt_fire = bkpt_match &&
                       ((state_q == ST_RUN) || (state_q == ST_STEP));

    // Next-state and datapath; RESET cmd overrides everything below it
    always_comb begin
        state_d      = state_q;
        boot_cnt_d   = boot_cnt_q;
        step_left_d  = step_left_q;
        boot_pc_d    = boot_pc_q;
        insn_count_d = insn_count_q;
        bkpt_hit_d   = bkpt_hit_q;

        if (fetch_pulse && core_en_q) begin
            insn_count_d = insn_count_q + CNT_WIDTH'(1);
        end
        if (op_run || op_step) begin
            bkpt_hit_d = 1'b0;
        end

        unique case (state_q)
            ST_BOOT: begin
                if (boot_cnt_q <= BW'(1)) begin
                    state_d = ST_HALTED;
                end else begin
                    boot_cnt_d = boot_cnt_q - BW'(1);
                end
            end
            ST_HALTED: begin
                if (op_run) begin
                    state_d = ST_RUN;
                end else if (op_step) begin
                    state_d     = ST_STEP;
                    step_left_d = (cmd_arg == '0) ? PC_WIDTH'(1) : cmd_arg;
                end
            end
            ST_RUN: begin
                if (bkpt_fire) begin
                    state_d    = ST_HALTED;
                    bkpt_hit_d = 1'b1;
                end else if (op_halt) begin
                    state_d = fetch_pulse ? ST_HALTED : ST_DRAIN;
                end
            end
            ST_STEP: begin
                if (fetch_pulse) begin
                    step_left_d = step_left_q - PC_WIDTH'(1);
                end
                if (bkpt_fire) begin
                    state_d    = ST_HALTED;
                    bkpt_hit_d = 1'b1;
                end else if (op_halt) begin
                    state_d = fetch_pulse ? ST_HALTED : ST_DRAIN;
                end else if (fetch_pulse && (step_left_q == PC_WIDTH'(1))) begin
                    state_d = ST_HALTED;
                end
            end
            ST_DRAIN: begin
                if (fetch_pulse) begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d    = ST_BOOT;
                boot_cnt_d = BOOT_LOAD;
            end
        endcase

        if (op_reset) begin
            state_d      = ST_BOOT;
            boot_cnt_d   = BOOT_LOAD;
            boot_pc_d    = cmd_arg;
            insn_count_d = '0;
            bkpt_hit_d   = 1'b0;
        end
    end

    // Outputs are registered from the next state so they move with it
    always_comb begin
        core_rst_n_d = (state_d != ST_BOOT);
        core_en_d    = core_active(state_d);
        cmd_ready_d  = cmd_open(state_d);
    end

    // Sequencer state and registered outputs
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q      <= ST_BOOT;
            boot_cnt_q   <= BOOT_LOAD;
            step_left_q  <= '0;
            boot_pc_q    <= RESET_PC;
            insn_count_q <= '0;
            bkpt_hit_q   <= 1'b0;
            core_rst_n_q <= 1'b0;
            core_en_q    <= 1'b0;
            cmd_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            boot_cnt_q   <= boot_cnt_d;
            step_left_q  <= step_left_d;
            boot_pc_q    <= boot_pc_d;
            insn_count_q <= insn_count_d;
            bkpt_hit_q   <= bkpt_hit_d;
            core_rst_n_q <= core_rst_n_d;
            core_en_q    <= core_en_d;
            cmd_ready_q  <= cmd_ready_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign core_rst_n = core_rst_n_q;
    assign core_en    = core_en_q;
    assign boot_pc    = boot_pc_q;
    assign state_o    = state_q;
    assign bkpt_hit   = bkpt_hit_q;
    assign insn_count = insn_count_q;

endmodule

// File: tb/tb_mcu_run_ctrl.sv
// Self-checking bench for mcu_run_ctrl.
// Breakpoint scenarios follow MCU_RUN_CTRL_BKPT_EN.
module tb_mcu_run_ctrl;
    import mcu_run_ctrl_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [7:0]  cmd_arg = 8'd0;
    logic [7:0]  currentPC = 8'd0;
    logic        fetch_pulse = 1'b0;
    logic        core_rst_n;
    logic        core_en;
    logic [7:0]  boot_pc;
    logic [2:0]  state_o;
    logic        bkpt_hit;
    logic [15:0] insn_count;

    int n_vec = 0;
    int n_err = 0;

    mcu_run_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_arg     (cmd_arg),
        .currentPC   (currentPC),
        .fetch_pulse (fetch_pulse),
        .core_rst_n  (core_rst_n),
        .core_en     (core_en),
        .boot_pc     (boot_pc),
        .state_o     (state_o),
        .bkpt_hit    (bkpt_hit),
        .insn_count  (insn_count)
    );

    always #5 Clk = ~Clk;

    // Behavioural reference: mode of the host-visible sequencer
    typedef enum int {M_BOOT, M_HALT, M_RUN, M_STEP, M_DRAIN} mode_t;
    mode_t      m_mode;
    int         m_boot_left;
    int         m_steps;
    logic [7:0] m_boot_pc;
    logic [15:0] m_count;
    bit         m_hit;
    bit         m_bp_on;
    logic [7:0] m_bp_pc;

    function automatic bit m_ready();
        return m_mode == M_HALT || m_mode == M_RUN || m_mode == M_STEP;
    endfunction

    function automatic bit m_en();
        return m_mode == M_RUN || m_mode == M_STEP || m_mode == M_DRAIN;
    endfunction

    function automatic logic [2:0] m_state();
        case (m_mode)
            M_BOOT:  return ST_BOOT;
            M_HALT:  return ST_HALTED;
            M_RUN:   return ST_RUN;
            M_STEP:  return ST_STEP;
            default: return ST_DRAIN;
        endcase
    endfunction

    task automatic model_update(bit rst_n, bit v, int op, logic [7:0] arg,
                                logic [7:0] pc, bit fp);
        bit acc;
        bit bp;
        if (!rst_n) begin
            m_mode = M_BOOT; m_boot_left = 4; m_steps = 0;
            m_boot_pc = 8'h00; m_count = 16'h0; m_hit = 0; m_bp_on = 0;
            m_bp_pc = 8'h00;
            return;
        end
        acc = v && m_ready();
        bp = 0;
`ifdef MCU_RUN_CTRL_BKPT_EN
        bp = m_bp_on && fp && pc == m_bp_pc &&
             (m_mode == M_RUN || m_mode == M_STEP);
`endif
        if (acc && op == 4) begin
            m_mode = M_BOOT; m_boot_left = 4; m_boot_pc = arg;
            m_count = 16'h0; m_hit = 0;
            return;
        end
        if (fp && m_en()) m_count = m_count + 16'd1;
        if (acc && (op == 1 || op == 3)) m_hit = 0;
`ifdef MCU_RUN_CTRL_BKPT_EN
        if (acc && op == 5) begin m_bp_pc = arg; m_bp_on = 1; end
        if (acc && op == 6) m_bp_on = 0;
`endif
        case (m_mode)
            M_BOOT: begin
                m_boot_left--;
                if (m_boot_left == 0) m_mode = M_HALT;
            end
            M_HALT: begin
                if (acc && op == 1) m_mode = M_RUN;
                else if (acc && op == 3) begin
                    m_mode = M_STEP;
                    m_steps = (arg == 0) ? 1 : int'(arg);
                end
            end
            M_RUN: begin
                if (bp) begin m_mode = M_HALT; m_hit = 1; end
                else if (acc && op == 2) m_mode = fp ? M_HALT : M_DRAIN;
            end
            M_STEP: begin
                if (bp) begin m_mode = M_HALT; m_hit = 1; end
                else if (acc && op == 2) m_mode = fp ? M_HALT : M_DRAIN;
                else if (fp) begin
                    m_steps--;
                    if (m_steps == 0) m_mode = M_HALT;
                end
            end
            default: if (fp) m_mode = M_HALT;
        endcase
    endtask

    // Apply one cycle of stimulus and advance the model on the same edge
    task automatic tick(bit v, logic [2:0] op, logic [7:0] arg,
                        logic [7:0] pc, bit fp);
        cmd_valid = v; cmd_op = op; cmd_arg = arg;
        currentPC = pc; fetch_pulse = fp;
        @(posedge Clk);
        model_update(Reset, v, int'(op), arg, pc, fp);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        tick(0, OP_NOP, 8'h00, 8'h00, 0);
        tick(0, OP_NOP, 8'h00, 8'h00, 0);
        n_vec++;
        if ({state_o, core_rst_n, core_en, cmd_ready, bkpt_hit} !==
            {ST_BOOT, 4'b0000}) begin
            n_err++;
            $display("FAIL reset_ctrl got %b want %b",
                     {state_o, core_rst_n, core_en, cmd_ready, bkpt_hit},
                     {ST_BOOT, 4'b0000});
        end
        n_vec++;
        if ({boot_pc, insn_count} !== 24'h0) begin
            n_err++;
            $display("FAIL reset_data got %h want 0", {boot_pc, insn_count});
        end
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(0, OP_NOP, 8'h00, 8'h00, 1);
            n_vec++;
            if (i < 3 && {state_o, core_rst_n} !== {ST_BOOT, 1'b0}) begin
                n_err++;
                $display("FAIL boot_hold[%0d] got %b", i, {state_o, core_rst_n});
            end else if (i == 3 &&
                {state_o, core_rst_n, core_en, cmd_ready, boot_pc} !==
                {ST_HALTED, 3'b101, 8'h00}) begin
                n_err++;
                $display("FAIL boot_done got %h", {state_o, core_rst_n,
                         core_en, cmd_ready, boot_pc});
            end
        end
        n_vec++;
        if (insn_count !== 16'd0) begin
            n_err++;
            $display("FAIL boot_count got %0d want 0", insn_count);
        end
    endtask

    task automatic test_run_drain();
        tick(1, OP_RUN, 8'h00, 8'h00, 0);
        n_vec++;
        if ({state_o, core_en} !== {ST_RUN, 1'b1}) begin
            n_err++;
            $display("FAIL run_enter got %b", {state_o, core_en});
        end
        for (int i = 0; i < 10; i++)
            tick(0, OP_NOP, 8'h00, 8'($urandom_range(0, 15)), 1);
        tick(1, OP_HALT, 8'h00, 8'h00, 0);
        n_vec++;
        if ({state_o, cmd_ready, core_en} !== {ST_DRAIN, 2'b01}) begin
            n_err++;
            $display("FAIL drain_enter got %b", {state_o, cmd_ready, core_en});
        end
        tick(0, OP_NOP, 8'h00, 8'h00, 0);
        n_vec++;
        if (state_o !== ST_DRAIN) begin
            n_err++;
            $display("FAIL drain_wait got %0d want %0d", state_o, ST_DRAIN);
        end
        tick(0, OP_NOP, 8'h00, 8'h00, 1);
        n_vec++;
        if ({state_o, core_en, insn_count} !== {ST_HALTED, 1'b0, 16'd11}) begin
            n_err++;
            $display("FAIL drain_done got %0d/%0d/%0d want 1/0/11",
                     state_o, core_en, insn_count);
        end
    endtask

    task automatic test_step();
        tick(1, OP_STEP, 8'd3, 8'h00, 0);
        for (int k = 1; k <= 3; k++) begin
            tick(0, OP_NOP, 8'h00, 8'h00, 0);
            tick(0, OP_NOP, 8'h00, 8'h00, 1);
            n_vec++;
            if (state_o !== ((k < 3) ? ST_STEP : ST_HALTED)) begin
                n_err++;
                $display("FAIL step3_pulse%0d got %0d", k, state_o);
            end
        end
        n_vec++;
        if (insn_count !== 16'd14) begin
            n_err++;
            $display("FAIL step3_count got %0d want 14", insn_count);
        end
        tick(1, OP_STEP, 8'd0, 8'h00, 0);
        n_vec++;
        if (state_o !== ST_STEP) begin
            n_err++;
            $display("FAIL step0_enter got %0d want %0d", state_o, ST_STEP);
        end
        tick(0, OP_NOP, 8'h00, 8'h00, 1);
        n_vec++;
        if ({state_o, insn_count} !== {ST_HALTED, 16'd15}) begin
            n_err++;
            $display("FAIL step0_done got %0d/%0d want 1/15",
                     state_o, insn_count);
        end
    endtask

    task automatic test_bkpt();
        tick(1, OP_SETBP, 8'h12, 8'h00, 0);
        tick(1, OP_RUN, 8'h00, 8'h00, 0);
        tick(0, OP_NOP, 8'h00, 8'h11, 1);
        n_vec++;
        if (state_o !== ST_RUN) begin
            n_err++;
            $display("FAIL bkpt_miss got %0d want %0d", state_o, ST_RUN);
        end
        tick(0, OP_NOP, 8'h00, 8'h12, 1);
`ifdef MCU_RUN_CTRL_BKPT_EN
        n_vec++;
        if ({state_o, bkpt_hit, core_en} !== {ST_HALTED, 2'b10}) begin
            n_err++;
            $display("FAIL bkpt_hit got %b", {state_o, bkpt_hit, core_en});
        end
        tick(1, OP_RUN, 8'h00, 8'h00, 0);
        n_vec++;
        if ({state_o, bkpt_hit} !== {ST_RUN, 1'b0}) begin
            n_err++;
            $display("FAIL bkpt_clear got %b", {state_o, bkpt_hit});
        end
        tick(1, OP_CLRBP, 8'h00, 8'h00, 0);
        tick(0, OP_NOP, 8'h00, 8'h12, 1);
        n_vec++;
        if (state_o !== ST_RUN) begin
            n_err++;
            $display("FAIL bkpt_disabled got %0d", state_o);
        end
`else
        n_vec++;
        if ({state_o, bkpt_hit} !== {ST_RUN, 1'b0}) begin
            n_err++;
            $display("FAIL bkpt_absent got %b", {state_o, bkpt_hit});
        end
`endif
        tick(1, OP_HALT, 8'h00, 8'h00, 1);
        n_vec++;
        if (state_o !== ST_HALTED) begin
            n_err++;
            $display("FAIL halt_with_pulse got %0d", state_o);
        end
    endtask

    task automatic test_reset_cmd();
        tick(1, OP_RUN, 8'h00, 8'h00, 0);
        for (int i = 0; i < 3; i++) tick(0, OP_NOP, 8'h00, 8'h05, 1);
        tick(1, OP_RESET, 8'h40, 8'h00, 1);
        n_vec++;
        if ({state_o, core_rst_n, core_en, cmd_ready, boot_pc, insn_count} !==
            {ST_BOOT, 3'b000, 8'h40, 16'h0}) begin
            n_err++;
            $display("FAIL reset_cmd got %h", {state_o, core_rst_n, core_en,
                     cmd_ready, boot_pc, insn_count});
        end
        for (int i = 0; i < 4; i++) begin
            tick(1, OP_RUN, 8'h00, 8'h00, 0);
            n_vec++;
            if (cmd_ready !== (i == 3)) begin
                n_err++;
                $display("FAIL reboot_ready[%0d] got %b", i, cmd_ready);
            end
        end
        tick(0, OP_NOP, 8'h00, 8'h00, 0);
        n_vec++;
        if ({state_o, boot_pc} !== {ST_HALTED, 8'h40}) begin
            n_err++;
            $display("FAIL reboot_done got %0d/%h", state_o, boot_pc);
        end
    endtask

    task automatic test_wrap();
        int guard;
        guard = 0;
        tick(1, OP_RUN, 8'h00, 8'h00, 0);
        while (m_count != 16'hFFFF && guard < 70000) begin
            tick(0, OP_NOP, 8'h00, 8'h30, 1);
            guard++;
        end
        n_vec++;
        if (insn_count !== 16'hFFFF) begin
            n_err++;
            $display("FAIL wrap_top got %h want ffff", insn_count);
        end
        tick(0, OP_NOP, 8'h00, 8'h30, 1);
        n_vec++;
        if ({state_o, insn_count} !== {ST_RUN, 16'h0}) begin
            n_err++;
            $display("FAIL wrap_zero got %0d/%h", state_o, insn_count);
        end
        tick(1, OP_HALT, 8'h00, 8'h30, 1);
        n_vec++;
        if ({state_o, core_en, insn_count} !== {ST_HALTED, 1'b0, 16'h1}) begin
            n_err++;
            $display("FAIL halt_direct got %0d/%b/%h",
                     state_o, core_en, insn_count);
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [7:0] arg;
        int r;
        for (int c = 0; c < 2000; c++) begin
            Reset = ($urandom_range(0, 299) != 0);
            r = $urandom_range(0, 99);
            if (r < 3) op = OP_RESET;
            else begin
                op = 3'($urandom_range(0, 7));
                if (op == OP_RESET) op = OP_NOP;
            end
            arg = (op == OP_STEP) ? 8'($urandom_range(0, 4)) :
                  ($urandom_range(0, 1) == 0) ? 8'h12 : 8'($urandom);
            tick($urandom_range(0, 2) == 0, op, arg,
                 ($urandom_range(0, 3) == 0) ? 8'h12 : 8'($urandom),
                 $urandom_range(0, 2) == 0);
            n_vec++;
            if ({state_o, core_rst_n, core_en, cmd_ready, bkpt_hit} !==
                {m_state(), !(m_mode == M_BOOT), m_en(), m_ready(), m_hit}) begin
                n_err++;
                $display("FAIL rand_ctrl@%0d got %b want %b", c,
                         {state_o, core_rst_n, core_en, cmd_ready, bkpt_hit},
                         {m_state(), !(m_mode == M_BOOT), m_en(), m_ready(), m_hit});
            end
            n_vec++;
            if (insn_count !== m_count) begin
                n_err++;
                $display("FAIL rand_count@%0d got %h want %h", c,
                         insn_count, m_count);
            end
            n_vec++;
            if (boot_pc !== m_boot_pc) begin
                n_err++;
                $display("FAIL rand_bootpc@%0d got %h want %h", c,
                         boot_pc, m_boot_pc);
            end
        end
        Reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_run_drain();
        test_step();
        test_bkpt();
        test_reset_cmd();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
